// File: rtl/ccta_pkg.sv
// Shared types and constants for the CCTA result accumulator slice.
// Saturation bounds are used only when CCTA_ACC_SAT_EN is defined.
package ccta_pkg;

    localparam int   CCTA_Q_W      = 5;
    localparam logic CCTA_CTRL_ADD = 1'b0;
    localparam logic CCTA_CTRL_SUB = 1'b1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/ccta_q_extend.sv
// Widens a 5-bit CCTA result to the accumulator width: zero-extended for
// sums (ctrl=0), sign-extended as 5-bit two's complement for differences.
module ccta_q_extend
    import ccta_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic [CCTA_Q_W-1:0] q_in,
    input  logic                ctrl_in,
    output logic [ACC_W-1:0]    op_o
);

    always_comb begin
        op_o = '0;
        case (ctrl_in)
            CCTA_CTRL_ADD: op_o = {{(ACC_W - CCTA_Q_W){1'b0}}, q_in};
            CCTA_CTRL_SUB: op_o = {{(ACC_W - CCTA_Q_W){q_in[CCTA_Q_W-1]}}, q_in};
        endcase
    end

endmodule

// File: rtl/ccta_result_acc.sv
// Window accumulator behind the CCTA add/subtract unit: sums N_SAMPLES results,
// then holds the signed total until consumed. Define CCTA_ACC_SAT_EN to clamp on overflow.
module ccta_result_acc
    import ccta_pkg::*;
#(
    parameter  int N_SAMPLES = 4,
    parameter  int ACC_W     = 10,
    localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CCTA_Q_W-1:0] q_in,
    input  logic                ctrl_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    sum,
    output logic                ovf,
    output logic [CNT_W-1:0]    count,
    output logic                dbg_state
);

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [ACC_W-1:0]   op;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;
    logic               ovf_step;
    logic [ACC_W:0]     wide;

`ifdef CCTA_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));
`endif

    ccta_q_extend #(.ACC_W(ACC_W)) u_ext (
        .q_in    (q_in),
        .ctrl_in (ctrl_in),
        .op_o    (op)
    );

    // One guard bit: overflow whenever the guard disagrees with the result sign.
    always_comb begin
        wide     = {acc_q[ACC_W-1], acc_q} + {op[ACC_W-1], op};
        ovf_step = wide[ACC_W] ^ wide[ACC_W-1];
        acc_d    = wide[ACC_W-1:0];
`ifdef CCTA_ACC_SAT_EN
        if (ovf_step) begin
            acc_d = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    // Handshake: a result transfers on a rising edge where in_valid & in_ready;
    // the total transfers on a rising edge where out_valid & out_ready. Neither
    // ready nor valid depends combinationally on the opposite side's signal.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        acc_q   <= acc_d;
                        count_q <= count_q + CNT_W'(1);
                        ovf_q   <= ovf_q | ovf_step;
                        if (count_q == CNT_W'(N_SAMPLES - 1)) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM) & ~rst;
    assign out_valid = (state_q == HOLD);
    assign sum       = acc_q;
    assign ovf       = ovf_q;
    assign count     = count_q;
    assign dbg_state = state_q;

endmodule
